// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI slave sequencing FSM.
//   SPI_WIDTH   - default number of bits per SPI byte
//   spi_state_t - sequencer state encoding
package spi_pkg;

   localparam int SPI_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GOT_ADDR,
      READ_LOAD,
      READ_SEND,
      WRITE_RECV,
      WRITE_STORE,
      DONE
   } spi_state_t;

endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: counts SCLK edge pulses within one SPI byte.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   clear - return count to 0 (wins over inc)
//   inc   - count one edge this cycle
//   last  - this increment is the WIDTH-th edge of the byte
// The count is $clog2(WIDTH)+1 bits wide. The owning FSM clears it in the
// same cycle that last is seen, so the count never goes above WIDTH-1.
module spi_bit_counter
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_WIDTH
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic last
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   assign last = inc && (count == CW'(WIDTH - 1));

endmodule

// File: rtl/spi_fsm.sv
// spi_fsm: SPI slave transaction sequencer. It receives an address byte
// whose last bit selects read or write. On a read it loads the shift
// register and then drives MISO for one byte. On a write it receives one
// data byte and stores it.
// Ports:
//   clk         - system clock
//   reset       - synchronous active-high reset
//   cs          - conditioned chip select, active low
//   sclkPosEdge - one-cycle pulse on an SCLK rising edge
//   sclkNegEdge - one-cycle pulse on an SCLK falling edge
//   rwBit       - R/W bit from the shift register (1 = read)
//   srWe        - shift register parallel load
//   addrWe      - address latch write enable
//   dmWe        - data memory write enable
//   misoBufe    - MISO tri-state buffer enable
//   abort       - one-cycle pulse when cs is released before the end of a transaction
// Build option: defining SPI_FSM_ABORT_EN enables abort. If the macro is
// not defined, abort is tied to 0.
//
// state       | meaning
// IDLE        | waiting for cs low
// GET_ADDR    | shifting in address + R/W on SCLK rising edges
// GOT_ADDR    | latch address, branch on rwBit
// READ_LOAD   | parallel-load read data into the shift register
// READ_SEND   | drive MISO, count SCLK falling edges
// WRITE_RECV  | shifting in write data on SCLK rising edges
// WRITE_STORE | write the received byte to data memory
// DONE        | byte complete, wait for cs high
module spi_fsm
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_WIDTH
) (
   input  logic clk,
   input  logic reset,
   input  logic cs,
   input  logic sclkPosEdge,
   input  logic sclkNegEdge,
   input  logic rwBit,
   output logic srWe,
   output logic addrWe,
   output logic dmWe,
   output logic misoBufe,
   output logic abort
);

   spi_state_t state, state_next;
   logic       cnt_clear;
   logic       cnt_inc;
   logic       cnt_last;
`ifdef SPI_FSM_ABORT_EN
   logic       abort_next;
   logic       abort_q;
`endif

   spi_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .last  (cnt_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_clear  = 1'b0;
      cnt_inc    = 1'b0;
`ifdef SPI_FSM_ABORT_EN
      abort_next = 1'b0;
`endif
      // A cs release takes priority over any SCLK edge pulse in the same cycle.
      if (state != IDLE && cs) begin
         state_next = IDLE;
         cnt_clear  = 1'b1;
`ifdef SPI_FSM_ABORT_EN
         abort_next = (state != DONE);
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (!cs) begin
                  state_next = GET_ADDR;
                  cnt_clear  = 1'b1;
               end
            end
            GET_ADDR: begin
               cnt_inc = sclkPosEdge;
               if (cnt_last) begin
                  state_next = GOT_ADDR;
                  cnt_clear  = 1'b1;
               end
            end
            GOT_ADDR:    state_next = rwBit ? READ_LOAD : WRITE_RECV;
            READ_LOAD:   state_next = READ_SEND;
            READ_SEND: begin
               cnt_inc = sclkNegEdge;
               if (cnt_last) begin
                  state_next = DONE;
                  cnt_clear  = 1'b1;
               end
            end
            WRITE_RECV: begin
               cnt_inc = sclkPosEdge;
               if (cnt_last) begin
                  state_next = WRITE_STORE;
                  cnt_clear  = 1'b1;
               end
            end
            WRITE_STORE: state_next = DONE;
            DONE:        state_next = DONE;
            default: begin
               state_next = IDLE;
               cnt_clear  = 1'b1;
            end
         endcase
      end
   end

   assign addrWe   = (state == GOT_ADDR);
   assign srWe     = (state == READ_LOAD);
   assign misoBufe = (state == READ_SEND);
   assign dmWe     = (state == WRITE_STORE);

`ifdef SPI_FSM_ABORT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         abort_q <= 1'b0;
      end else begin
         abort_q <= abort_next;
      end
   end
   assign abort = abort_q;
`else
   assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_spi_fsm.sv
module tb_spi_fsm;

   localparam int WIDTH = 8;
`ifdef SPI_FSM_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   // model phases of a transaction
   localparam int P_IDLE = 0, P_ADDR = 1, P_GOT = 2, P_RLOAD = 3,
                  P_RSEND = 4, P_WRECV = 5, P_WSTORE = 6, P_DONE = 7;
   // which SCLK edge advances each phase: 0 none, 1 rising, 2 falling
   int edge_kind [8] = '{0, 1, 0, 0, 2, 1, 0, 0};
   // the phase reached after WIDTH counted edges
   int after_byte [8] = '{0, P_GOT, 0, 0, P_DONE, P_WSTORE, 0, 0};

   logic clk = 1'b0;
   logic reset, cs, sclkPosEdge, sclkNegEdge, rwBit;
   logic srWe, addrWe, dmWe, misoBufe, abort;

   int total = 0;
   int bad = 0;
   bit checking = 1'b0;

   int m_phase = P_IDLE;
   int m_edges = 0;
   bit m_abort = 1'b0;

   spi_fsm #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .cs          (cs),
      .sclkPosEdge (sclkPosEdge),
      .sclkNegEdge (sclkNegEdge),
      .rwBit       (rwBit),
      .srWe        (srWe),
      .addrWe      (addrWe),
      .dmWe        (dmWe),
      .misoBufe    (misoBufe),
      .abort       (abort)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of the transaction-level model, using the inputs seen at the edge.
   task automatic model_step();
      if (reset) begin
         m_phase = P_IDLE;
         m_edges = 0;
         m_abort = 1'b0;
         return;
      end
      m_abort = ABORT_EN && cs && m_phase != P_IDLE && m_phase != P_DONE;
      if (m_phase == P_IDLE) begin
         if (!cs) begin
            m_phase = P_ADDR;
            m_edges = 0;
         end
         return;
      end
      if (cs) begin
         m_phase = P_IDLE;
         m_edges = 0;
         return;
      end
      if ((edge_kind[m_phase] == 1 && sclkPosEdge) || (edge_kind[m_phase] == 2 && sclkNegEdge)) begin
         m_edges++;
         if (m_edges == WIDTH) begin
            m_edges = 0;
            m_phase = after_byte[m_phase];
         end
      end else if (m_phase == P_GOT) begin
         m_phase = rwBit ? P_RLOAD : P_WRECV;
      end else if (m_phase == P_RLOAD) begin
         m_phase = P_RSEND;
      end else if (m_phase == P_WSTORE) begin
         m_phase = P_DONE;
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("addrWe",   addrWe,   32'(m_phase == P_GOT));
         chk("srWe",     srWe,     32'(m_phase == P_RLOAD));
         chk("misoBufe", misoBufe, 32'(m_phase == P_RSEND));
         chk("dmWe",     dmWe,     32'(m_phase == P_WSTORE));
         chk("abort",    abort,    32'(m_abort));
      end
   end

   // drive inputs for one cycle, clock once, leave us at the next falling edge
   task automatic cyc(input bit r, input bit c, input bit p, input bit n, input bit w);
      reset = r; cs = c; sclkPosEdge = p; sclkNegEdge = n; rwBit = w;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; cs = 1'b1; sclkPosEdge = 1'b0; sclkNegEdge = 1'b0; rwBit = 1'b0;
      @(negedge clk);
      cyc(1, 1, 0, 0, 0);
      checking = 1'b1;
      chk("rst_addrWe", addrWe, 0);
      chk("rst_count", dut.u_bit_counter.count, 0);

      // reset in WRITE_RECV after 3 rising edges
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < WIDTH; i++) cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 1, 0, 0);
      chk("rstmid_outs", {srWe, addrWe, dmWe, misoBufe, abort}, 0);
      chk("rstmid_count", dut.u_bit_counter.count, 0);
      cyc(0, 1, 0, 0, 0);

      // write, with falling edges ignored in WRITE_RECV and rising edges ignored in DONE
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < WIDTH; i++) cyc(0, 0, 1, 0, 0);
      chk("wr_addrWe_on", addrWe, 1);
      cyc(0, 0, 0, 0, 0);
      chk("wr_addrWe_off", addrWe, 0);
      for (int i = 0; i < WIDTH; i++) cyc(0, 0, 0, 1, 0);
      chk("wr_neg_ignored", dmWe, 0);
      for (int i = 0; i < WIDTH - 1; i++) cyc(0, 0, 1, 0, 0);
      chk("wr_7th_no_dmWe", dmWe, 0);
      cyc(0, 0, 1, 0, 0);
      chk("wr_dmWe_on", dmWe, 1);
      cyc(0, 0, 0, 0, 0);
      chk("wr_dmWe_off", dmWe, 0);
      for (int i = 0; i < WIDTH; i++) cyc(0, 0, 1, 0, 0);
      chk("done_pos_ignored", {srWe, addrWe, dmWe, misoBufe}, 0);
      cyc(0, 1, 0, 0, 0);
      chk("wr_release_abort", abort, 0);

      // read
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < WIDTH; i++) cyc(0, 0, 1, 0, 1);
      chk("rd_addrWe_on", addrWe, 1);
      cyc(0, 0, 0, 0, 1);
      chk("rd_srWe_on", srWe, 1);
      cyc(0, 0, 0, 0, 1);
      chk("rd_miso_on", misoBufe, 1);
      for (int i = 0; i < WIDTH - 1; i++) cyc(0, 0, 0, 1, 1);
      chk("rd_miso_7th", misoBufe, 1);
      cyc(0, 0, 0, 1, 1);
      chk("rd_miso_off", misoBufe, 0);
      cyc(0, 1, 0, 0, 0);
      chk("rd_done_no_abort", abort, 0);

      // early cs release during the address byte
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      chk("early_addrWe", addrWe, 0);
      chk("early_abort", abort, 32'(ABORT_EN));
      cyc(0, 1, 0, 0, 0);
      chk("early_abort_1cyc", abort, 0);
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < WIDTH; i++) cyc(0, 0, 1, 0, 0);
      chk("after_early_full_byte", addrWe, 1);

      // random traffic against the model
      for (int i = 0; i < 5000; i++) begin
         int e;
         e = $urandom_range(0, 2);
         cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 39) == 0),
             (e == 1), (e == 2), $urandom_range(0, 1));
      end

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_fsm.md
SPI_FSM -- requirements
Module: spi_fsm

Interface
REQ-001 Parameter: WIDTH, 8, bits per SPI byte (7 address bits + 1 R/W bit, or 8 data bits).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: cs  input  1  conditioned chip select, active-low (0 = transaction in progress).
REQ-005 Port: sclkPosEdge  input  1  single-cycle pulse, conditioned SCLK rising edge.
REQ-006 Port: sclkNegEdge  input  1  single-cycle pulse, conditioned SCLK falling edge.
REQ-007 Port: rwBit  input  1  shift register parallelDataOut[0]; 1 = read, 0 = write.
REQ-008 Port: srWe  output  1  parallel-load strobe to shift register (drives parallelLoad).
REQ-009 Port: addrWe  output  1  address latch write enable.
REQ-010 Port: dmWe  output  1  data memory write enable.
REQ-011 Port: misoBufe  output  1  MISO tri-state buffer enable.
REQ-012 Port: abort  output  1  one-cycle pulse on early CS release (see Configuration).

Function
REQ-013 States SHALL be IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SEND, WRITE_RECV, WRITE_STORE, DONE.
REQ-014 Outputs SHALL be Moore decodes of the registered state: addrWe=1 only in GOT_ADDR; srWe=1 only in READ_LOAD; misoBufe=1 only in READ_SEND; dmWe=1 only in WRITE_STORE; all others 0.
REQ-015 IDLE: cs==0 -> GET_ADDR, bit counter cleared to 0.
REQ-016 GET_ADDR: counter increments on each sclkPosEdge; the cycle the WIDTH-th pulse is seen -> GOT_ADDR, counter cleared.
REQ-017 GOT_ADDR: lasts exactly one cycle; rwBit==1 -> READ_LOAD, else -> WRITE_RECV.
REQ-018 READ_LOAD: exactly one cycle -> READ_SEND.
REQ-019 READ_SEND: counter increments on each sclkNegEdge; WIDTH-th pulse -> DONE, counter cleared.
REQ-020 WRITE_RECV: counter increments on each sclkPosEdge; WIDTH-th pulse -> WRITE_STORE, counter cleared.
REQ-021 WRITE_STORE: exactly one cycle -> DONE.
REQ-022 DONE: all outputs 0; cs==1 -> IDLE; further SCLK edges ignored.
REQ-023 cs==1 in any non-IDLE state SHALL force next state IDLE and clear the counter, overriding any edge pulse in the same cycle.
REQ-024 Edge pulses of the polarity not counted in the current state SHALL be ignored; edges in IDLE ignored.
REQ-025 Counter SHALL be $clog2(WIDTH)+1 bits and SHALL never exceed WIDTH.

Reset
REQ-026 reset==1 at a clk edge SHALL set state IDLE, counter 0, all outputs 0 the following cycle, from any state including mid-transaction; reset wins over cs and edges.

Configuration
REQ-027 SPI_FSM_ABORT_EN defined: abort SHALL pulse 1 for one cycle when REQ-023 fires from GET_ADDR, GOT_ADDR, READ_LOAD, READ_SEND, WRITE_RECV or WRITE_STORE; not from DONE.
REQ-028 SPI_FSM_ABORT_EN undefined: abort port SHALL exist and be tied 0; all other behaviour identical.

Structure
REQ-029 Shared package spi_pkg SHALL hold the state enum typedef and the default byte-width constant (8).
REQ-030 One sub-module, spi_bit_counter (clear, increment, WIDTH-reached flag), SHALL implement the bit counter.

Verification
REQ-031 Reset: assert reset in WRITE_RECV after 3 pos edges -> next cycle IDLE, all outputs 0, counter 0.
REQ-032 Write: cs=0, 8 pos edges with rwBit=0 at 8th -> addrWe 1 cycle; 8 more pos edges -> dmWe 1 cycle; misoBufe and srWe stay 0; cs=1 -> IDLE.
REQ-033 Read: cs=0, 8 pos edges with rwBit=1 -> addrWe 1 cycle, then srWe 1 cycle, then misoBufe 1 through 8 neg edges, then 0 in DONE.
REQ-034 Early CS: cs=1 after 5 pos edges in GET_ADDR, same cycle as a pos edge -> IDLE, no addrWe; abort=1 one cycle with SPI_FSM_ABORT_EN, 0 without.
REQ-035 Ignored edges: in WRITE_RECV drive 8 neg edges only -> stays WRITE_RECV; in DONE drive 8 pos edges -> stays DONE, dmWe 0.
